// File: rtl/bw_mul_wb_initiator_if.sv
// Command, response and Wishbone master bundle between the multiplier initiator and its environment.
interface bw_mul_wb_initiator_if #(parameter int P_W = 16);
  logic           cmd_valid;
  logic           cmd_ready;
  logic [7:0]     cmd_a;
  logic [7:0]     cmd_b;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [P_W-1:0] rsp_p;
  logic           rsp_err;
  logic           wbm_cyc_o;
  logic           wbm_stb_o;
  logic           wbm_we_o;
  logic [31:0]    wbm_adr_o;
  logic [31:0]    wbm_dat_o;
  logic [3:0]     wbm_sel_o;
  logic [31:0]    wbm_dat_i;
  logic           wbm_ack_i;

  modport master (
    input  cmd_valid, cmd_a, cmd_b, rsp_ready, wbm_dat_i, wbm_ack_i,
    output cmd_ready, rsp_valid, rsp_p, rsp_err,
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o
  );

  modport slave (
    output cmd_valid, cmd_a, cmd_b, rsp_ready, wbm_dat_i, wbm_ack_i,
    input  cmd_ready, rsp_valid, rsp_p, rsp_err,
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o
  );
endinterface

// File: rtl/bw_mul_wb_initiator.sv
// Wishbone initiator for the Baugh-Wooley multiplier slave: writes {b,a}, reads the product back,
// returns it (or a timeout error) on the response port. One transaction in flight at a time.
module bw_mul_wb_initiator #(
  parameter logic [31:0] WB_ADDR   = 32'h3000_0000,
  parameter logic [31:0] RD_OFFSET = 32'h0000_0004,
  parameter int          P_W       = 16,
  parameter int          TIMEOUT   = 16
) (
  input logic                   wb_clk_i,
  input logic                   wb_rst_i,
  bw_mul_wb_initiator_if.master bus
);
  localparam int            CW       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 2);

  typedef enum logic [1:0] {IDLE, WR, RD, RSP} state_t;

  typedef struct packed {
    logic [7:0] b;
    logic [7:0] a;
  } ops_t;

  state_t         r_state, w_next;
  ops_t           r_ops;
  logic [CW-1:0]  r_cnt;
  logic [P_W-1:0] r_p;
  logic           r_err;

  logic           w_stb, w_we, w_ack, w_last, w_tout;
  logic [31:0]    w_adr, w_dat;
  logic           w_unused;

  // Ack only counts while strobing; the last stb cycle without ack is the timeout.
  assign w_ack    = w_stb & bus.wbm_ack_i;
  assign w_last   = (r_cnt == CNT_LAST);
  assign w_tout   = w_stb & ~bus.wbm_ack_i & w_last;
  assign w_unused = &{1'b0, bus.wbm_dat_i};

  always_comb begin
    w_next        = r_state;
    w_stb         = 1'b0;
    w_we          = 1'b0;
    w_adr         = '0;
    w_dat         = '0;
    bus.cmd_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    case (r_state)
      IDLE: begin
        bus.cmd_ready = 1'b1;
        if (bus.cmd_valid) w_next = WR;
      end
      WR: begin
        w_stb = 1'b1;
        w_we  = 1'b1;
        w_adr = WB_ADDR;
        w_dat = {16'h0, r_ops};
        if (bus.wbm_ack_i)  w_next = RD;
        else if (w_last)    w_next = RSP;
      end
      RD: begin
        w_stb = 1'b1;
        w_adr = WB_ADDR + RD_OFFSET;
        if (bus.wbm_ack_i || w_last) w_next = RSP;
      end
      RSP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign bus.wbm_cyc_o = w_stb;
  assign bus.wbm_stb_o = w_stb;
  assign bus.wbm_we_o  = w_we;
  assign bus.wbm_adr_o = w_adr;
  assign bus.wbm_dat_o = w_dat;
  assign bus.wbm_sel_o = {4{w_stb}};
  assign bus.rsp_p     = r_p;
  assign bus.rsp_err   = r_err;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) r_state <= IDLE;
    else          r_state <= w_next;
  end

  // Counter sits at zero whenever no stb is waiting, so it is clear on entry to WR and RD.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_ops <= '0;
      r_cnt <= '0;
      r_p   <= '0;
      r_err <= 1'b0;
    end else begin
      if (r_state == IDLE && bus.cmd_valid) r_ops <= '{b: bus.cmd_b, a: bus.cmd_a};
      r_cnt <= (w_stb && !bus.wbm_ack_i && !w_last) ? r_cnt + 1'b1 : '0;
      if (r_state == RD && w_ack) begin
        r_p   <= bus.wbm_dat_i[P_W-1:0];
        r_err <= 1'b0;
      end else if (w_tout) begin
        r_p   <= '0;
        r_err <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_bw_mul_wb_initiator.sv
// Bench for bw_mul_wb_initiator: scripted Wishbone slave, event-level model checked every cycle,
// and directed transactions with hand-computed latencies and products.
module tb_bw_mul_wb_initiator;
  localparam logic [31:0] ADDR   = 32'h3000_0000;
  localparam logic [31:0] RD_OFF = 32'h0000_0004;
  localparam int          TO     = 16;

  logic clk, rst;
  bw_mul_wb_initiator_if #(.P_W(16)) ifc();

  bw_mul_wb_initiator #(
    .WB_ADDR(ADDR), .RD_OFFSET(RD_OFF), .P_W(16), .TIMEOUT(TO)
  ) dut (
    .wb_clk_i(clk),
    .wb_rst_i(rst),
    .bus(ifc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Scripted slave: acks after wait_wr / wait_rd stalled stb cycles (99 = never).
  int          wait_wr, wait_rd, wcnt, cyc_n;
  logic [31:0] rd_data;
  logic        stray_ack;
  assign ifc.wbm_ack_i = stray_ack |
                         (ifc.wbm_stb_o & (wcnt == (ifc.wbm_we_o ? wait_wr : wait_rd)));
  assign ifc.wbm_dat_i = (ifc.wbm_stb_o && !ifc.wbm_we_o) ? rd_data : 32'hDEAD_BEEF;

  initial begin wcnt = 0; cyc_n = 0; end
  always @(posedge clk) begin
    cyc_n <= cyc_n + 1;
    wcnt  <= (ifc.wbm_stb_o && !ifc.wbm_ack_i) ? wcnt + 1 : 0;
  end

  // Model state: transaction open, still in write phase, response due, stalled stb run.
  bit          m_open, m_wph, m_due;
  int          m_run;
  logic [15:0] m_p;
  logic        m_err;
  logic [7:0]  m_a, m_b;
  int          mon_stb, mon_rd;
  logic [31:0] mon_wadr, mon_wdat, mon_radr;
  initial begin
    m_open = 0; m_wph = 0; m_due = 0; m_run = 0; m_p = '0; m_err = 0; m_a = '0; m_b = '0;
    mon_stb = 0; mon_rd = 0; mon_wadr = '0; mon_wdat = '0; mon_radr = '0;
  end

  always @(negedge clk) begin : cmp
    bit o, w, d, eb;
    int r;
    logic [15:0] p;
    logic e;
    logic [7:0] a, b;
    o = m_open; w = m_wph; d = m_due; r = m_run; p = m_p; e = m_err; a = m_a; b = m_b;
    if (rst) begin
      chk("rst_cmd_ready", ifc.cmd_ready, 1);
      chk("rst_rsp_valid", ifc.rsp_valid, 0);
      chk("rst_cyc", ifc.wbm_cyc_o, 0);
      chk("rst_stb", ifc.wbm_stb_o, 0);
      chk("rst_rsp_p", ifc.rsp_p, 0);
      chk("rst_rsp_err", ifc.rsp_err, 0);
      o = 0; w = 0; d = 0; r = 0;
    end else begin
      eb = o && !d;
      chk("cmd_ready", ifc.cmd_ready, !o);
      chk("cyc", ifc.wbm_cyc_o, eb);
      chk("stb", ifc.wbm_stb_o, eb);
      chk("rsp_valid", ifc.rsp_valid, d);
      chk("we", ifc.wbm_we_o, eb && w);
      chk("sel", ifc.wbm_sel_o, eb ? 4'hF : 4'h0);
      chk("adr", ifc.wbm_adr_o, !eb ? 32'h0 : (w ? ADDR : ADDR + RD_OFF));
      chk("dat_o", ifc.wbm_dat_o, (eb && w) ? {16'h0, b, a} : 32'h0);
      if (d) begin
        chk("rsp_p", ifc.rsp_p, p);
        chk("rsp_err", ifc.rsp_err, e);
      end
      if (ifc.wbm_stb_o) begin
        mon_stb <= mon_stb + 1;
        if (ifc.wbm_we_o) begin
          mon_wadr <= ifc.wbm_adr_o;
          mon_wdat <= ifc.wbm_dat_o;
        end else begin
          mon_rd   <= mon_rd + 1;
          mon_radr <= ifc.wbm_adr_o;
        end
      end
      if (d) begin
        if (ifc.rsp_ready) begin o = 0; d = 0; end
      end else if (eb) begin
        if (ifc.wbm_ack_i) begin
          r = 0;
          if (w) w = 0;
          else begin d = 1; p = ifc.wbm_dat_i[15:0]; e = 0; end
        end else begin
          r++;
          if (r == TO - 1) begin d = 1; p = 16'h0; e = 1; r = 0; end
        end
      end else if (!o && ifc.cmd_valid) begin
        o = 1; w = 1; a = ifc.cmd_a; b = ifc.cmd_b; r = 0;
        mon_stb <= 0;
        mon_rd  <= 0;
      end
    end
    m_open <= o; m_wph <= w; m_due <= d; m_run <= r; m_p <= p; m_err <= e; m_a <= a; m_b <= b;
  end

  task automatic run_txn(input string nm, input logic [7:0] a, input logic [7:0] b,
                         input int ww, input int wr, input logic [31:0] rd,
                         input logic [15:0] ep, input logic ee, input int elat,
                         input int hold, input bit pulse);
    int k, t0, t1;
    wait_wr = ww; wait_rd = wr; rd_data = rd;
    @(posedge clk); #1;
    ifc.cmd_valid = 1'b1; ifc.cmd_a = a; ifc.cmd_b = b;
    k = 0; @(negedge clk);
    while (!ifc.cmd_ready && k < 50) begin @(negedge clk); k++; end
    chk({nm, "_accept"}, ifc.cmd_ready, 1);
    t0 = cyc_n;
    @(posedge clk); #1; ifc.cmd_valid = 1'b0;
    k = 0; @(negedge clk);
    while (!ifc.rsp_valid && k < 200) begin @(negedge clk); k++; end
    t1 = cyc_n;
    chk({nm, "_rsp_seen"}, ifc.rsp_valid, 1);
    chk({nm, "_lat"}, t1 - t0, elat);
    chk({nm, "_p"}, ifc.rsp_p, ep);
    chk({nm, "_err"}, ifc.rsp_err, ee);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      ifc.cmd_valid = pulse && (i == hold / 2);
      ifc.cmd_a = 8'h11; ifc.cmd_b = 8'h22;
      @(negedge clk);
      if (pulse && i == hold / 2) chk({nm, "_busy_ready"}, ifc.cmd_ready, 0);
      chk({nm, "_hold_valid"}, ifc.rsp_valid, 1);
      chk({nm, "_hold_p"}, ifc.rsp_p, ep);
    end
    @(posedge clk); #1; ifc.cmd_valid = 1'b0; ifc.rsp_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1; ifc.rsp_ready = 1'b0;
    @(negedge clk);
    chk({nm, "_rsp_drop"}, ifc.rsp_valid, 0);
    chk({nm, "_idle_ready"}, ifc.cmd_ready, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_chk);
    $fatal(1);
  end

  initial begin
    int k, t0, t1, t2;
    rst = 1'b1; stray_ack = 1'b0; wait_wr = 0; wait_rd = 0; rd_data = '0;
    ifc.cmd_valid = 1'b0; ifc.cmd_a = '0; ifc.cmd_b = '0; ifc.rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("init_cmd_ready", ifc.cmd_ready, 1);
    chk("init_adr", ifc.wbm_adr_o, 0);
    @(posedge clk); #3; rst = 1'b0;

    // Zero-wait slave, 3*5.
    run_txn("zw", 8'h03, 8'h05, 0, 0, 32'h0000_000F, 16'h000F, 0, 3, 0, 0);
    chk("zw_wdat", mon_wdat, 32'h0000_0503);
    chk("zw_wadr", mon_wadr, 32'h3000_0000);
    chk("zw_radr", mon_radr, 32'h3000_0004);
    // Signed pair -3*5 with three wait states per cycle.
    run_txn("ws3", 8'hFD, 8'h05, 3, 3, 32'h0000_FFF1, 16'hFFF1, 0, 9, 0, 0);
    // Write never acked: 15 stb cycles, no read.
    run_txn("wto", 8'h12, 8'h34, 99, 0, 32'h0000_0123, 16'h0000, 1, 16, 0, 0);
    chk("wto_stb_cycles", mon_stb, 15);
    chk("wto_rd_cycles", mon_rd, 0);
    // Ack on the very last allowed stb cycle wins; upper read bits dropped.
    run_txn("edge", 8'h01, 8'h02, 14, 14, 32'h1234_ABCD, 16'hABCD, 0, 31, 0, 0);
    // Read never acked: error clears the previous product.
    run_txn("rto", 8'h04, 8'h04, 0, 99, 32'h0000_0010, 16'h0000, 1, 17, 0, 0);
    chk("rto_rd_cycles", mon_rd, 15);
    // Slow consumer, with a cmd pulse while the response waits. 127*-128 = -16256.
    run_txn("hold", 8'h7F, 8'h80, 0, 0, 32'hFFFF_C080, 16'hC080, 0, 3, 10, 1);

    // Back-to-back with rsp_ready held, stray ack while stb is low.
    wait_wr = 0; wait_rd = 0; rd_data = 32'h0000_0006;
    @(posedge clk); #1;
    ifc.rsp_ready = 1'b1; ifc.cmd_valid = 1'b1; ifc.cmd_a = 8'h02; ifc.cmd_b = 8'h03;
    k = 0; @(negedge clk);
    while (!ifc.cmd_ready && k < 50) begin @(negedge clk); k++; end
    t0 = cyc_n;
    @(posedge clk); #1; ifc.cmd_a = 8'hFF; ifc.cmd_b = 8'hFF;
    k = 0; @(negedge clk);
    while (!ifc.rsp_valid && k < 50) begin @(negedge clk); k++; end
    t1 = cyc_n;
    chk("b2b_lat", t1 - t0, 3);
    chk("b2b_p1", ifc.rsp_p, 16'h0006);
    @(posedge clk); #1; stray_ack = 1'b1; rd_data = 32'h0000_0001;
    @(negedge clk);
    chk("b2b_ready", ifc.cmd_ready, 1);
    chk("b2b_stray_stb", ifc.wbm_stb_o, 0);
    @(posedge clk); #1; stray_ack = 1'b0; ifc.cmd_valid = 1'b0;
    k = 0; @(negedge clk);
    while (!(ifc.wbm_stb_o && ifc.wbm_we_o) && k < 20) begin @(negedge clk); k++; end
    t2 = cyc_n;
    chk("b2b_gap", t2 - t1, 2);
    chk("b2b_wdat2", ifc.wbm_dat_o, 32'h0000_FFFF);
    k = 0; @(negedge clk);
    while (!ifc.rsp_valid && k < 50) begin @(negedge clk); k++; end
    chk("b2b_p2", ifc.rsp_p, 16'h0001);
    @(posedge clk); #1; ifc.rsp_ready = 1'b0;
    repeat (2) @(negedge clk);

    // Reset asserted mid-write.
    wait_wr = 99;
    @(posedge clk); #1; ifc.cmd_valid = 1'b1; ifc.cmd_a = 8'h0A; ifc.cmd_b = 8'h0B;
    @(negedge clk);
    @(posedge clk); #1; ifc.cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_wr_stb", ifc.wbm_stb_o, 1);
    @(posedge clk); #3; rst = 1'b1; #1;
    chk("rst_async_stb", ifc.wbm_stb_o, 0);
    chk("rst_async_cyc", ifc.wbm_cyc_o, 0);
    @(negedge clk);
    @(posedge clk); #3; rst = 1'b0; wait_wr = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("post_rst_ready", ifc.cmd_ready, 1);
      chk("post_rst_no_rsp", ifc.rsp_valid, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
